// File: rtl/sd_join_pkg.sv
// sd_join_pkg
// Shared types and constants for the srdy/drdy join block and its lane buffers.
//   laneCount_t        - occupancy of one lane buffer (0..2)
//   SD_JOIN_LANE_DEPTH - number of entries per lane buffer
//   laneFull()         - true when a lane buffer cannot accept another word
package sd_join_pkg;

  localparam int SD_JOIN_LANE_DEPTH = 2;

  typedef logic [1:0] laneCount_t;

  // A lane is full once its count reaches the buffer depth.
  function automatic logic laneFull(input laneCount_t count);
    return (count == laneCount_t'(SD_JOIN_LANE_DEPTH));
  endfunction

endpackage

// File: rtl/sd_join_lane.sv
// sd_join_lane
// Two-entry buffer for one input lane of the join. The ready output is a
// register that depends only on occupancy, so downstream ready can never
// ripple combinationally back to the source.
// Ports:
//   clk         clock
//   rst         synchronous active-low reset
//   srdy_i      source valid for this lane
//   data_i      source word for this lane
//   drdy_o      registered ready (buffer not full, low during reset)
//   pop_i       remove the head entry (only asserted when nonEmpty_o)
//   headData_o  oldest buffered word
//   nonEmpty_o  at least one word is buffered
module sd_join_lane
  import sd_join_pkg::*;
#(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             srdy_i,
  input  logic [width-1:0] data_i,
  output logic             drdy_o,
  input  logic             pop_i,
  output logic [width-1:0] headData_o,
  output logic             nonEmpty_o
);

  logic [width-1:0] mem_q [SD_JOIN_LANE_DEPTH];
  logic             wptr_q;
  logic             rptr_q;
  laneCount_t       count_q;
  laneCount_t       count_d;
  logic             ready_q;
  logic             ready_d;
  logic             push;

  // A word is taken only while the registered ready is high, which already
  // guarantees there is room for it.
  assign push       = srdy_i & ready_q;
  assign nonEmpty_o = (count_q != laneCount_t'(0));
  assign headData_o = mem_q[rptr_q];
  assign drdy_o     = ready_q;

  // Next occupancy: a simultaneous push and pop leaves the count unchanged.
  // Ready is derived from the next count so that it is registered yet still
  // reflects the buffer state in the very next cycle.
  always_comb begin
    count_d = count_q + laneCount_t'(push) - laneCount_t'(pop_i);
    ready_d = ~laneFull(count_d);
  end

  // Pointer, count and ready state. Ready stays low for the whole reset and
  // rises only at the first clock edge that sees reset released.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
      count_q <= '0;
      ready_q <= 1'b0;
    end else begin
      if (push) begin
        wptr_q <= ~wptr_q;
      end
      if (pop_i) begin
        rptr_q <= ~rptr_q;
      end
      count_q <= count_d;
      ready_q <= ready_d;
    end
  end

  // Storage is written only on an accepted push, so unknown source data on
  // idle cycles never enters the buffer.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/sd_join_atomic.sv
// sd_join_atomic
// Joins join_cnt independent srdy/drdy lanes into one output beat built from
// one word of every lane. A beat is loaded only when all lanes hold a word,
// and then every lane pops exactly once. Lane buffers and the output register
// keep p_drdy away from c_drdy, breaking mirror/join combinational loops.
// Ports:
//   clk     clock
//   rst     synchronous active-low reset
//   c_srdy  per-lane source valid
//   c_drdy  per-lane registered ready
//   c_data  lane i word at [i*width +: width]
//   p_srdy  registered output valid
//   p_drdy  consumer ready
//   p_data  registered joined beat, lane i word at [i*width +: width]
module sd_join_atomic
  import sd_join_pkg::*;
#(
  parameter int join_cnt = 2,
  parameter int width    = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [join_cnt-1:0]       c_srdy,
  output logic [join_cnt-1:0]       c_drdy,
  input  logic [join_cnt*width-1:0] c_data,
  output logic                      p_srdy,
  input  logic                      p_drdy,
  output logic [join_cnt*width-1:0] p_data
);

  logic [join_cnt-1:0]       nonEmpty;
  logic [join_cnt*width-1:0] headFlat;
  logic                      load;
  logic                      outVld_q;
  logic                      outVld_d;
  logic [join_cnt*width-1:0] outData_q;
  logic [join_cnt*width-1:0] outData_d;

  // One buffer per lane; each lane's head lands directly in its slot of the
  // flattened vector, so the concatenation is pure wiring.
  for (genvar i = 0; i < join_cnt; i++) begin : gLane
    sd_join_lane #(
      .width(width)
    ) uLane (
      .clk        (clk),
      .rst        (rst),
      .srdy_i     (c_srdy[i]),
      .data_i     (c_data[i*width +: width]),
      .drdy_o     (c_drdy[i]),
      .pop_i      (load),
      .headData_o (headFlat[i*width +: width]),
      .nonEmpty_o (nonEmpty[i])
    );
  end

  // A beat is loaded when every lane has a word and the output register is
  // either empty or being drained this cycle. Otherwise a consumed beat just
  // clears the valid; the data register holds its last value.
  always_comb begin
    load      = (&nonEmpty) & (~outVld_q | p_drdy);
    outVld_d  = outVld_q;
    outData_d = outData_q;
    if (load) begin
      outVld_d  = 1'b1;
      outData_d = headFlat;
    end else if (p_drdy & outVld_q) begin
      outVld_d = 1'b0;
    end
  end

  // Output register; reset discards any pending beat and zeroes the data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      outVld_q  <= 1'b0;
      outData_q <= '0;
    end else begin
      outVld_q  <= outVld_d;
      outData_q <= outData_d;
    end
  end

  assign p_srdy = outVld_q;
  assign p_data = outData_q;

endmodule

// File: doc/sd_join_atomic.md
Name: sd_join_atomic

Overview:
- Downstream counterpart of the atomic mirror. Joins join_cnt independent srdy/drdy streams into one output beat, concatenating one word from each lane.
- A beat is emitted only when every lane has a word pending.
- Each lane has a 2-entry buffer and the output is registered, so p_drdy never reaches c_drdy combinationally. This breaks the combo loops that a mirror/join pair would otherwise form.
- Sits at the reconvergence point after branches fed by a mirror.

Parameters:
- join_cnt, 2, number of input lanes (>=2).
- width, 32, data width per lane.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset.
- c_srdy  input  join_cnt  per-lane source valid.
- c_drdy  output  join_cnt  per-lane ready; registered (function of lane occupancy only).
- c_data  input  join_cnt*width  lane i occupies bits [i*width +: width].
- p_srdy  output  1  output valid; registered.
- p_drdy  input  1  consumer ready.
- p_data  output  join_cnt*width  joined beat; lane i word at [i*width +: width]; registered.

Behaviour:
- Reset (rst==0 at a clock edge): all lane counts=0, lane read/write pointers=0, out_vld=0.
  - While rst==0 and on the first cycle after: p_srdy=0, p_data=0, c_drdy=all 0.
  - From the cycle after the first edge with rst==1: c_drdy=all 1.
  - Reset mid-operation discards all buffered and output data; no partial beat is emitted afterwards.
- Lane buffer i, 2 entries, count_i in {0,1,2}:
  - c_drdy[i] = (count_i != 2).
  - push_i = c_srdy[i] & c_drdy[i]; writes c_data lane i at wptr_i, wptr_i toggles.
  - pop_i = load; rptr_i toggles.
  - count_i += push_i - pop_i. Simultaneous push and pop at count 1 or 2 keeps the count. At count 0, only a push is possible, never a pop.
- Output stage:
  - load = (&nonempty) & (~out_vld | p_drdy).
  - On load: out_data <= concat of head entries of all lanes; out_vld <= 1; every lane pops exactly once, atomically.
  - Else if p_drdy & out_vld: out_vld <= 0.
  - p_srdy = out_vld; p_data = out_data (holds stable while p_srdy & ~p_drdy).
- Latency: a word accepted in cycle n (last lane to arrive) appears on p_data with p_srdy in cycle n+2 at the earliest.
- Throughput: 1 beat/cycle sustained when all lanes supply every cycle and p_drdy=1.
- Lane skew: a lane may run up to 2 words ahead of the slowest lane. It then stalls (c_drdy=0) until a load pops it.
- Order: beats are emitted in per-lane FIFO order. The k-th word of every lane forms beat k.
- Backpressure: with p_drdy=0 and out_vld=1, no load occurs. Lanes fill to 2, then c_drdy drops; no data is lost or duplicated.
- X handling: c_data is sampled only on push. p_data changes only on load or reset.

Decomposition:
- Shared package sd_join_pkg:
  - typedef for lane count (2-bit, values 0..2).
  - constant SD_JOIN_LANE_DEPTH=2.
- Sub-module sd_join_lane (width param): the 2-entry lane buffer with push/pop/count/head-data/nonempty/not-full. Instantiated join_cnt times in a generate loop.
- Top level contains load logic, the output register and concatenation.

Test Plan:
1. Reset, then both lanes push 0xA/0xB in the same cycle with p_drdy=1 -> p_srdy=1 two cycles later, p_data={0xB,0xA}, one beat only.
2. Streaming: lane0 sends 1,2,3,4 and lane1 sends 11,12,13,14 every cycle, p_drdy=1 -> four consecutive beats {11,1},{12,2},{13,3},{14,4} with no bubbles.
3. Skew: lane0 sends 5,6,7 back-to-back, lane1 idle -> c_drdy[0] drops after 2 accepts, p_srdy stays 0. Lane1 then sends 9 -> beat {9,5}; c_drdy[0] rises the next cycle.
4. Backpressure: hold p_drdy=0 while both lanes stream -> first beat holds stable on p_data, both lanes fill to 2, c_drdy=0. Release p_drdy -> beats drain in order, nothing lost or duplicated.
5. Reset mid-operation: assert rst with out_vld=1 and lane counts 2/1 -> next cycle p_srdy=0, p_data=0, c_drdy=0. After release, c_drdy=all 1 and no stale beat appears.
6. join_cnt=3, width=8: lanes arrive on different cycles with values 0x01/0x02/0x03 -> a single beat 0x030201 is emitted 2 cycles after the last arrival.
